mem_rr_arbiter: RTL

- Round-robin arbiter that shares one single-port synchronous memory (1-cycle read latency, registered rddata/rddatavalid) between NREQ requesters.
- Issues at most one command per cycle (read or write) to the memory through registered command outputs.
- Routes each returning read word to the requester that issued it.
- Sits between client blocks and the memory instance's interface signals.

---
 rtl/mem_rr_arbiter_if.sv | 37 +++
 rtl/mem_rr_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: requester-side and memory-side signal bundle
// for the round-robin memory arbiter.
interface mem_rr_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 6
);
  logic [NREQ-1:0]        req_i;
  logic [NREQ-1:0]        we_i;
  logic [NREQ*AWIDTH-1:0] addr_i;
  logic [NREQ*DWIDTH-1:0] wdata_i;
  logic [NREQ-1:0]        gnt_o;
  logic [DWIDTH-1:0]      rdata_o;
  logic [NREQ-1:0]        rvalid_o;
  logic                   mem_wr_o;
  logic                   mem_rd_o;
  logic [AWIDTH-1:0]      mem_addr_o;
  logic [DWIDTH-1:0]      mem_data_o;
  logic [DWIDTH-1:0]      mem_rddata_i;
  logic                   mem_rddatavalid_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    input  mem_rddata_i, mem_rddatavalid_i,
    output gnt_o, rdata_o, rvalid_o,
    output mem_wr_o, mem_rd_o,
    output mem_addr_o, mem_data_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    output mem_rddata_i, mem_rddatavalid_i,
    input  gnt_o, rdata_o, rvalid_o,
    input  mem_wr_o, mem_rd_o,
    input  mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin share of one single-port sync memory
// among NREQ requesters, with read-return routing to the issuer.
module mem_rr_arbiter #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 6
) (
  input logic             clk_i,
  input logic             rst_ni,
  mem_rr_arbiter_if.slave bus
);
  localparam int IDXW = $clog2(NREQ);

  logic [IDXW-1:0]   r_ptr;
  logic              r_wr;
  logic              r_rd;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_data;
  logic              r_s1_v;
  logic [IDXW-1:0]   r_s1_idx;
  logic              r_s2_v;
  logic [IDXW-1:0]   r_s2_idx;

  logic              w_found;
  logic [IDXW-1:0]   w_win;
  logic [IDXW-1:0]   w_cand;
  logic [NREQ-1:0]   w_gnt;
  logic              w_we;
  logic [AWIDTH-1:0] w_addr;
  logic [DWIDTH-1:0] w_data;
  logic [NREQ-1:0]   w_rvalid;
  logic [IDXW-1:0]   w_ptr_nxt;

  // search from r_ptr upward with wrap; first requester wins
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = IDXW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && bus.req_i[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_gnt  = '0;
    w_we   = 1'b0;
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDXW'(i)) begin
        w_gnt[i] = w_found & rst_ni;
        w_we     = bus.we_i[i];
        w_addr   = bus.addr_i[i*AWIDTH +: AWIDTH];
        w_data   = bus.wdata_i[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_win == IDXW'(NREQ - 1))
                   ? '0 : w_win + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr    <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_s1_v   <= 1'b0;
      r_s1_idx <= '0;
      r_s2_v   <= 1'b0;
      r_s2_idx <= '0;
    end else begin
      r_wr     <= w_found & w_we;
      r_rd     <= w_found & ~w_we;
      r_s1_v   <= w_found & ~w_we;
      r_s1_idx <= w_win;
      r_s2_v   <= r_s1_v;
      r_s2_idx <= r_s1_idx;
      if (w_found) begin
        r_ptr  <= w_ptr_nxt;
        r_addr <= w_addr;
        r_data <= w_data;
      end
    end
  end

  // stage2 lines up with the memory's registered read return
  always_comb begin
    w_rvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_rvalid[i] = r_s2_v
                  & bus.mem_rddatavalid_i
                  & (r_s2_idx == IDXW'(i));
    end
  end

  assign bus.gnt_o      = w_gnt;
  assign bus.rvalid_o   = w_rvalid;
  assign bus.rdata_o    = (|w_rvalid)
                        ? bus.mem_rddata_i : '0;
  assign bus.mem_wr_o   = r_wr;
  assign bus.mem_rd_o   = r_rd;
  assign bus.mem_addr_o = r_addr;
  assign bus.mem_data_o = r_data;
endmodule
